// File: rtl/adc_fifo_drain_scheduler_if.sv
// Shared FIFO read-mux and tagged sample stream between the drain scheduler
// and its surroundings (FIFO bank on one side, readout logic on the other).
interface adc_fifo_drain_scheduler_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12
);
    localparam int CW = $clog2(NUM_CHANNELS);

    logic [CW-1:0]           fifo_addr;
    logic [NUM_CHANNELS-1:0] fifo_rd_en;
    logic                    fifo_not_empty;
    logic                    fifo_full;
    logic [DATA_WIDTH-1:0]   fifo_dout;
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic [CW-1:0]           m_chan;

    modport master (
        output fifo_addr, fifo_rd_en, m_valid, m_data, m_chan,
        input  fifo_not_empty, fifo_full, fifo_dout, m_ready
    );

    modport slave (
        input  fifo_addr, fifo_rd_en, m_valid, m_data, m_chan,
        output fifo_not_empty, fifo_full, fifo_dout, m_ready
    );
endinterface

// File: rtl/adc_fifo_drain_scheduler.sv
// Round-robin burst drain of per-channel ADC FIFOs behind one read mux,
// emitting channel-tagged samples on a valid/ready stream.
module adc_fifo_drain_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int BURST_LEN    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clear_flags,
    adc_fifo_drain_scheduler_if.master bus,
    output logic                    busy,
    output logic [NUM_CHANNELS-1:0] full_seen,
    output logic [31:0]             word_count
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] PTR_LAST   = CW'(NUM_CHANNELS - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, READ, WAIT, PRESENT, ROTATE} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           chan_q, chan_d;
    logic [BW-1:0]           burst_q, burst_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [NUM_CHANNELS-1:0] full_q, full_d;
    logic [31:0]             count_q, count_d;
    logic [NUM_CHANNELS-1:0] rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            chan_q  <= '0;
            burst_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            full_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
            burst_q <= burst_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            full_q  <= full_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        chan_d  = chan_q;
        burst_d = burst_q;
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        rd_en   = '0;
        case (state_q)
            IDLE:   if (enable) state_d = SETTLE;
            // fifo_addr has been stable a full cycle, so the muxed flag is trustworthy
            SETTLE: state_d = bus.fifo_not_empty ? READ : ROTATE;
            READ: begin
                rd_en[ptr_q] = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                data_d  = bus.fifo_dout;
                chan_d  = ptr_q;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (bus.m_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    burst_d = burst_q + BW'(1);
                    state_d = (burst_q == BURST_LAST || !enable) ? ROTATE : SETTLE;
                end
            end
            ROTATE: begin
                ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + CW'(1);
                burst_d = '0;
                state_d = enable ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Set has priority over a coincident clear so no full event is missed
        full_d = clear_flags ? '0 : full_q;
        if (state_q != IDLE && bus.fifo_full) full_d[ptr_q] = 1'b1;
    end

    assign bus.fifo_addr  = ptr_q;
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid_q;
    assign bus.m_data     = data_q;
    assign bus.m_chan     = chan_q;
    assign busy           = (state_q != IDLE);
    assign full_seen      = full_q;
    assign word_count     = count_q;
endmodule

// File: tb/tb_adc_fifo_drain_scheduler.sv
// Bench for adc_fifo_drain_scheduler: queue-based FIFO bank, round-robin
// burst reference model feeding a scoreboard, stream monitor on the output.
module tb_adc_fifo_drain_scheduler;
    localparam int NCH   = 4;
    localparam int DW    = 12;
    localparam int BL    = 8;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [1:0]    chan;
        logic [DW-1:0] data;
    } word_t;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clear_flags = 1'b0;
    logic            busy;
    logic [NCH-1:0]  full_seen;
    logic [31:0]     word_count;

    adc_fifo_drain_scheduler_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) bus ();

    adc_fifo_drain_scheduler #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear_flags(clear_flags),
        .bus(bus), .busy(busy), .full_seen(full_seen), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // FIFO bank: storage written by stimulus, read pointers advanced by rd_en
    logic [DW-1:0] mem [NCH][DEPTH];
    int            wr_ptr [NCH] = '{0, 0, 0, 0};
    int            rd_ptr [NCH] = '{0, 0, 0, 0};
    logic [NCH-1:0] full_force = '0;
    logic [DW-1:0] mdl_q [NCH][$];

    assign bus.fifo_not_empty = (wr_ptr[bus.fifo_addr] != rd_ptr[bus.fifo_addr]);
    assign bus.fifo_full      = full_force[bus.fifo_addr];

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (bus.fifo_rd_en[i] && wr_ptr[i] != rd_ptr[i]) begin
                bus.fifo_dout <= mem[i][rd_ptr[i] % DEPTH];
                rd_ptr[i]     <= rd_ptr[i] + 1;
            end
        end
    end

    int ready_mode = 1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    ntests = 0, nfail = 0;
    word_t exp_q[$];
    int    hs_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream monitor: scoreboard compare on handshake, hold-stability under stall
    logic           stall_pend = 1'b0;
    logic [DW-1:0]  stall_data;
    logic [1:0]     stall_chan;
    word_t          mon_e;
    logic [NCH-1:0] mon_oh;
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (bus.fifo_rd_en != '0) begin
                mon_oh = '0;
                mon_oh[bus.fifo_addr] = 1'b1;
                check("rd_en while m_valid", bus.m_valid, 0);
                check("rd_en on empty fifo", bus.fifo_not_empty, 1);
                check("rd_en onehot", bus.fifo_rd_en, mon_oh);
            end
            if (bus.m_valid) begin
                if (stall_pend) begin
                    check("hold m_data", bus.m_data, stall_data);
                    check("hold m_chan", bus.m_chan, stall_chan);
                end
                if (bus.m_ready === 1'b1) begin
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        ntests++;
                        nfail++;
                        $display("FAIL unexpected word: got chan %0d data %0h expected none",
                                 bus.m_chan, bus.m_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("word chan", bus.m_chan, mon_e.chan);
                        check("word data", bus.m_data, mon_e.data);
                    end
                    stall_pend = 1'b0;
                end else begin
                    stall_pend = 1'b1;
                    stall_data = bus.m_data;
                    stall_chan = bus.m_chan;
                end
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [DW-1:0] d);
        mem[ch][wr_ptr[ch] % DEPTH] = d;
        wr_ptr[ch]++;
        mdl_q[ch].push_back(d);
    endtask

    // Reference: from start channel, take up to BL words per channel, rotate, until all empty
    task automatic model_drain(input int start);
        int    p, left;
        word_t w;
        p = start;
        left = 0;
        for (int c = 0; c < NCH; c++) left += mdl_q[c].size();
        while (left > 0) begin
            for (int k = 0; k < BL && mdl_q[p].size() > 0; k++) begin
                w.chan = 2'(p);
                w.data = mdl_q[p].pop_front();
                exp_q.push_back(w);
                left--;
            end
            p = (p + 1) % NCH;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, " drained"}, exp_q.size(), 0);
        exp_q.delete();
        tick(2);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.m_valid && n < 60) begin
            tick(1);
            n++;
        end
        check({name, " m_valid seen"}, bus.m_valid, 1);
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.fifo_addr, bus.fifo_rd_en, bus.m_valid, bus.m_data, bus.m_chan,
                busy, full_seen, word_count};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        clear_flags = 1'b0;
        tick(2);
        check("reset outputs", all_outs(), 0);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev, nx;
        int bad, changes, last_chg, n, total;

        // All empty: pure SETTLE/ROTATE scan, 2 cycles per channel
        do_reset();
        enable = 1'b1;
        bad = 0; changes = 0; last_chg = -1; prev = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en != '0 || bus.m_valid) bad++;
            if (k > 0 && bus.fifo_addr != prev) begin
                nx = prev + 2'd1;
                if (bus.fifo_addr != nx) bad++;
                if (last_chg >= 0 && k - last_chg != 2) bad++;
                last_chg = k;
                changes++;
            end
            prev = bus.fifo_addr;
        end
        check("scan bad cycles", bad, 0);
        check("scan step count >= 8", changes >= 8, 1);
        enable = 1'b0;
        tick(4);

        // Three words on ch2 at full rate
        do_reset();
        load(2, 12'h111); load(2, 12'h222); load(2, 12'h333);
        model_drain(0);
        ready_mode = 1;
        tick(1);
        hs_q.delete();
        enable = 1'b1;
        wait_drain("ch2 three words");
        check("ch2 handshakes", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("ch2 spacing 1", hs_q[1] - hs_q[0], 4);
            check("ch2 spacing 2", hs_q[2] - hs_q[1], 4);
        end
        check("ch2 word_count", word_count, 3);
        enable = 1'b0;

        // Burst rotation: ch0 x20, ch1 x2
        do_reset();
        for (int k = 0; k < 20; k++) load(0, 12'($urandom));
        for (int k = 0; k < 2; k++) load(1, 12'($urandom));
        model_drain(0);
        enable = 1'b1;
        wait_drain("burst rotation");
        check("burst word_count", word_count, 22);
        enable = 1'b0;

        // Backpressure: ready low 10 cycles while valid
        do_reset();
        ready_mode = 0;
        tick(1);
        load(0, 12'h5A5); load(0, 12'hA5A);
        model_drain(0);
        enable = 1'b1;
        wait_valid("stall");
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en != '0) n++;
        end
        check("rd_en during stall", n, 0);
        ready_mode = 1;
        wait_drain("stall release");
        check("stall word_count", word_count, 2);
        enable = 1'b0;

        // Disable during WAIT: word completes, then idle; resume at ptr+1
        do_reset();
        load(0, 12'h0A1); load(0, 12'h0A2); load(0, 12'h0A3); load(1, 12'h1D1);
        exp_q.push_back('{chan: 2'd0, data: mdl_q[0].pop_front()});
        enable = 1'b1;
        n = 0;
        while (bus.fifo_rd_en == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("disable: read seen", bus.fifo_rd_en != '0, 1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        wait_drain("disable in WAIT");
        check("disable busy", busy, 0);
        check("disable word_count", word_count, 1);
        model_drain(1);
        enable = 1'b1;
        wait_drain("resume at ptr+1");
        check("resume word_count", word_count, 4);

        // Reset while a word is being presented
        ready_mode = 0;
        load(1, 12'hABC);
        mdl_q[1].delete();
        wait_valid("reset mid-present");
        tick(2);
        rst = 1'b1;
        tick(1);
        check("reset mid-present outputs", all_outs(), 0);
        rst = 1'b0;
        enable = 1'b0;
        tick(2);

        // Random fills with random backpressure
        for (int it = 0; it < 6; it++) begin
            do_reset();
            total = 0;
            for (int c = 0; c < NCH; c++) begin
                n = $urandom_range(0, 12);
                for (int k = 0; k < n; k++) load(c, 12'($urandom));
                total += n;
            end
            model_drain(0);
            ready_mode = 2;
            enable = 1'b1;
            wait_drain("random");
            check("random word_count", word_count, total);
            enable = 1'b0;
        end

        // Sticky full flag on channel 3, then clear
        do_reset();
        full_force = 4'b1000;
        enable = 1'b1;
        n = 0;
        while (full_seen == '0 && n < 40) begin
            tick(1);
            n++;
        end
        check("full_seen set", full_seen, 4'b1000);
        full_force = '0;
        tick(2);
        check("full_seen sticky", full_seen, 4'b1000);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("full_seen cleared", full_seen, 0);
        enable = 1'b0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
